// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, direct-mapped I-cache, miss handling
// toward the memory controller and branch/commit redirects.
module inst_fetch #(
   parameter int          ICACHE_IDX = 5,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        iJP_en,
   input  logic [31:0] iJP_pc,
   input  logic        iIQ_full,
   output logic        oIQ_en,
   output logic [31:0] oIQ_inst,
   output logic [31:0] oIQ_pc,
   output logic        oMC_en,
   output logic [31:0] oMC_addr,
   input  logic        iMC_done,
   input  logic [31:0] iMC_inst
);

   localparam int LINES = 1 << ICACHE_IDX;
   localparam int TAGW  = 30 - ICACHE_IDX;

   typedef enum logic {IDLE, MISS} state_t;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       jp_pc_q, jp_pc_d;
   logic              pend_q, pend_d;
   logic              iq_en_q, iq_en_d;
   logic [31:0]       iq_inst_q, iq_inst_d;
   logic [31:0]       iq_pc_q, iq_pc_d;
   logic              mc_en_q, mc_en_d;
   logic [31:0]       mc_addr_q, mc_addr_d;

   logic [LINES-1:0]  valid_q;
   logic [TAGW-1:0]   tag_q  [LINES];
   logic [31:0]       data_q [LINES];

   logic [ICACHE_IDX-1:0] idx;
   logic [ICACHE_IDX-1:0] fill_idx;
   logic                  hit;
   logic                  fill;

   assign idx      = pc_q[ICACHE_IDX+1:2];
   assign fill_idx = mc_addr_q[ICACHE_IDX+1:2];
   assign hit      = valid_q[idx] && (tag_q[idx] == pc_q[31:ICACHE_IDX+2]);

   assign oIQ_en   = iq_en_q;
   assign oIQ_inst = iq_inst_q;
   assign oIQ_pc   = iq_pc_q;
   assign oMC_en   = mc_en_q;
   assign oMC_addr = mc_addr_q;

   // Next-state: redirect beats hit/miss; a miss holds its request until done.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      jp_pc_d   = jp_pc_q;
      pend_d    = pend_q;
      iq_en_d   = iq_en_q;
      iq_inst_d = iq_inst_q;
      iq_pc_d   = iq_pc_q;
      mc_en_d   = mc_en_q;
      mc_addr_d = mc_addr_q;
      fill      = 1'b0;
      if (rdy) begin
         iq_en_d = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (iJP_en) begin
                  pc_d = iJP_pc;
               end else if (hit) begin
                  if (!iIQ_full) begin
                     iq_en_d   = 1'b1;
                     iq_inst_d = data_q[idx];
                     iq_pc_d   = pc_q;
                     pc_d      = pc_q + 32'd4;
                  end
               end else begin
                  mc_en_d   = 1'b1;
                  mc_addr_d = pc_q;
                  state_d   = MISS;
               end
            end
            MISS: begin
               if (iMC_done) begin
                  fill    = 1'b1;
                  mc_en_d = 1'b0;
                  state_d = IDLE;
                  if (pend_q || iJP_en) begin
                     pc_d   = iJP_en ? iJP_pc : jp_pc_q;
                     pend_d = 1'b0;
                  end else if (!iIQ_full) begin
                     iq_en_d   = 1'b1;
                     iq_inst_d = iMC_inst;
                     iq_pc_d   = pc_q;
                     pc_d      = pc_q + 32'd4;
                  end
               end else if (iJP_en) begin
                  pend_d  = 1'b1;
                  jp_pc_d = iJP_pc;
               end
            end
         endcase
      end
   end

   // State, output and cache registers; rdy low freezes everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         jp_pc_q   <= '0;
         pend_q    <= 1'b0;
         iq_en_q   <= 1'b0;
         iq_inst_q <= '0;
         iq_pc_q   <= '0;
         mc_en_q   <= 1'b0;
         mc_addr_q <= '0;
         valid_q   <= '0;
         for (int i = 0; i < LINES; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         jp_pc_q   <= jp_pc_d;
         pend_q    <= pend_d;
         iq_en_q   <= iq_en_d;
         iq_inst_q <= iq_inst_d;
         iq_pc_q   <= iq_pc_d;
         mc_en_q   <= mc_en_d;
         mc_addr_q <= mc_addr_d;
         if (fill) begin
            valid_q[fill_idx] <= 1'b1;
            tag_q[fill_idx]   <= mc_addr_q[31:ICACHE_IDX+2];
            data_q[fill_idx]  <= iMC_inst;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: scoreboard of expected
// {pc, inst} emits against a behavioural memory controller.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst, rdy, iJP_en, iIQ_full, iMC_done;
   logic [31:0] iJP_pc, iMC_inst;
   logic        oIQ_en, oMC_en;
   logic [31:0] oIQ_inst, oIQ_pc, oMC_addr;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];
   logic [63:0] e, o;
   logic        ok, stable, flag;

   inst_fetch #(.ICACHE_IDX(5), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .iJP_en(iJP_en), .iJP_pc(iJP_pc), .iIQ_full(iIQ_full),
      .oIQ_en(oIQ_en), .oIQ_inst(oIQ_inst), .oIQ_pc(oIQ_pc),
      .oMC_en(oMC_en), .oMC_addr(oMC_addr),
      .iMC_done(iMC_done), .iMC_inst(iMC_inst)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: sim time exceeded");
      $fatal(1);
   end

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a < 32'd8) ? 32'h0000_0013 : (32'hC0DE_0000 ^ a);
   endfunction

   // advance one clock, sample after the edge, log emits
   task automatic step();
      @(posedge clk);
      #1;
      if (oIQ_en === 1'b1) obs_q.push_back({oIQ_pc, oIQ_inst});
   endtask

   task automatic wait_req(output logic got);
      got = (oMC_en === 1'b1);
      for (int i = 0; i < 50 && !got; i++) begin
         step();
         got = (oMC_en === 1'b1);
      end
   endtask

   // memory controller: answer the current request after lat cycles
   task automatic serve(input int lat, input logic jp,
                        input logic [31:0] jpc, output logic st);
      logic [31:0] a;
      a  = oMC_addr;
      st = (oMC_en === 1'b1);
      for (int i = 1; i < lat; i++) begin
         step();
         if (oMC_en !== 1'b1 || oMC_addr !== a) st = 1'b0;
      end
      iMC_done = 1'b1;
      iMC_inst = mem(a);
      iJP_en   = jp;
      iJP_pc   = jpc;
      step();
      iMC_done = 1'b0;
      iMC_inst = '0;
      iJP_en   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1; iJP_en = 1'b0; iJP_pc = '0;
      iIQ_full = 1'b0; iMC_done = 1'b0; iMC_inst = '0;
      step(); step();
      n_chk++;
      if ({oIQ_en, oMC_en, oMC_addr} !== 34'h0) begin
         n_fail++;
         $display("FAIL reset_mc: got en=%b mc=%b addr=%h want 0", oIQ_en, oMC_en, oMC_addr);
      end
      n_chk++;
      if ({oIQ_pc, oIQ_inst} !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_iq: got pc=%h inst=%h want 0", oIQ_pc, oIQ_inst);
      end
      rst = 1'b0;
   endtask

   task automatic test_cold_start();
      step();
      n_chk++;
      if (oMC_en !== 1'b1 || oMC_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL cold_req: got en=%b addr=%h want 1/0", oMC_en, oMC_addr);
      end
      exp_q.push_back({32'h0, 32'h13});
      serve(5, 1'b0, '0, stable);
      n_chk++;
      if (stable !== 1'b1) begin
         n_fail++;
         $display("FAIL cold_hold: got stable=%b want 1", stable);
      end
      n_chk++;
      if (oMC_en !== 1'b0) begin
         n_fail++;
         $display("FAIL cold_drop: got mc_en=%b want 0", oMC_en);
      end
      step();
      n_chk++;
      if (oMC_en !== 1'b1 || oMC_addr !== 32'h4) begin
         n_fail++;
         $display("FAIL cold_next: got en=%b addr=%h want 1/4", oMC_en, oMC_addr);
      end
      exp_q.push_back({32'h4, 32'h13});
      serve(2, 1'b0, '0, stable);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL cold_emit: got none want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++;
               $display("FAIL cold_emit: got %h want %h", o, e);
            end
         end
      end
   endtask

   task automatic test_hit_stream();
      wait_req(ok);
      n_chk++;
      if (!ok || oMC_addr !== 32'h8) begin
         n_fail++;
         $display("FAIL fill8_req: got ok=%b addr=%h want 1/8", ok, oMC_addr);
      end
      exp_q.push_back({32'h8, mem(32'h8)});
      serve(1, 1'b0, '0, stable);
      wait_req(ok);
      n_chk++;
      if (!ok || oMC_addr !== 32'hC) begin
         n_fail++;
         $display("FAIL fillC_req: got ok=%b addr=%h want 1/C", ok, oMC_addr);
      end
      exp_q.push_back({32'hC, mem(32'hC)});
      serve(3, 1'b0, '0, stable);
      iJP_en = 1'b1; iJP_pc = 32'h0;
      step();
      iJP_en = 1'b0;
      n_chk++;
      if (oIQ_en !== 1'b0) begin
         n_fail++;
         $display("FAIL redir_quiet: got iq_en=%b want 0", oIQ_en);
      end
      for (int i = 0; i < 4; i++)
         exp_q.push_back({32'(i * 4), mem(32'(i * 4))});
      flag = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (oMC_en !== 1'b0) flag = 1'b1;
      end
      n_chk++;
      if (flag !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_nomc: got mc_seen=%b want 0", flag);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL hit_emit: got none want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++;
               $display("FAIL hit_emit: got %h want %h", o, e);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      iJP_en = 1'b1; iJP_pc = 32'h8;
      step();
      iJP_en = 1'b0;
      iIQ_full = 1'b1;
      flag = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (oIQ_en !== 1'b0 || oMC_en !== 1'b0) flag = 1'b1;
      end
      n_chk++;
      if (flag !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_hold: got activity=%b want 0", flag);
      end
      iIQ_full = 1'b0;
      exp_q.push_back({32'h8, mem(32'h8)});
      step();
      iJP_en = 1'b1; iJP_pc = 32'h100;
      step();
      iJP_en = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL bp_emit: got none want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++;
               $display("FAIL bp_emit: got %h want %h", o, e);
            end
         end
      end
      n_chk++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL bp_single: got %0d extra emits want 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_redirect_miss();
      step();
      n_chk++;
      if (oMC_en !== 1'b1 || oMC_addr !== 32'h100) begin
         n_fail++;
         $display("FAIL rm_req: got en=%b addr=%h want 1/100", oMC_en, oMC_addr);
      end
      iJP_en = 1'b1; iJP_pc = 32'h200;
      step();
      iJP_en = 1'b0;
      serve(4, 1'b0, '0, stable);
      n_chk++;
      if (stable !== 1'b1) begin
         n_fail++;
         $display("FAIL rm_hold: got stable=%b want 1", stable);
      end
      n_chk++;
      if (oIQ_en !== 1'b0 || obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL rm_discard: got iq_en=%b emits=%0d want 0", oIQ_en, obs_q.size());
         obs_q.delete();
      end
      iJP_en = 1'b1; iJP_pc = 32'h100;
      step();
      iJP_en = 1'b0;
      exp_q.push_back({32'h100, mem(32'h100)});
      step();
      n_chk++;
      if (oMC_en !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_filled: got mc_en=%b want 0", oMC_en);
      end
      iJP_en = 1'b1; iJP_pc = 32'h200;
      step();
      iJP_en = 1'b0;
      step();
      n_chk++;
      if (oMC_en !== 1'b1 || oMC_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL rm_next: got en=%b addr=%h want 1/200", oMC_en, oMC_addr);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL rm_emit: got none want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++;
               $display("FAIL rm_emit: got %h want %h", o, e);
            end
         end
      end
   endtask

   task automatic test_simul_done_jp();
      serve(3, 1'b1, 32'h40, stable);
      n_chk++;
      if (oIQ_en !== 1'b0 || obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL sj_discard: got iq_en=%b emits=%0d want 0", oIQ_en, obs_q.size());
         obs_q.delete();
      end
      step();
      n_chk++;
      if (oMC_en !== 1'b1 || oMC_addr !== 32'h40) begin
         n_fail++;
         $display("FAIL sj_pc: got en=%b addr=%h want 1/40", oMC_en, oMC_addr);
      end
      exp_q.push_back({32'h40, mem(32'h40)});
      serve(2, 1'b0, '0, stable);
      iJP_en = 1'b1; iJP_pc = 32'h200;
      step();
      iJP_en = 1'b0;
      exp_q.push_back({32'h200, mem(32'h200)});
      step();
      n_chk++;
      if (oMC_en !== 1'b0) begin
         n_fail++;
         $display("FAIL sj_filled: got mc_en=%b want 0", oMC_en);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL sj_emit: got none want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++;
               $display("FAIL sj_emit: got %h want %h", o, e);
            end
         end
      end
   endtask

   task automatic test_wrap();
      iJP_en = 1'b1; iJP_pc = 32'hFFFF_FFFC;
      step();
      iJP_en = 1'b0;
      step();
      n_chk++;
      if (oMC_en !== 1'b1 || oMC_addr !== 32'hFFFF_FFFC) begin
         n_fail++;
         $display("FAIL wrap_req: got en=%b addr=%h want 1/FFFFFFFC", oMC_en, oMC_addr);
      end
      exp_q.push_back({32'hFFFF_FFFC, mem(32'hFFFF_FFFC)});
      serve(1, 1'b0, '0, stable);
      step();
      n_chk++;
      if (oMC_en !== 1'b1 || oMC_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap_pc: got en=%b addr=%h want 1/0", oMC_en, oMC_addr);
      end
      exp_q.push_back({32'h0, 32'h13});
      serve(1, 1'b0, '0, stable);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL wrap_emit: got none want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++;
               $display("FAIL wrap_emit: got %h want %h", o, e);
            end
         end
      end
   endtask

   task automatic test_rdy_reset();
      iJP_en = 1'b1; iJP_pc = 32'h300;
      step();
      iJP_en = 1'b0;
      step();
      n_chk++;
      if (oMC_en !== 1'b1 || oMC_addr !== 32'h300) begin
         n_fail++;
         $display("FAIL rr_req: got en=%b addr=%h want 1/300", oMC_en, oMC_addr);
      end
      step();
      rdy = 1'b0;
      flag = 1'b0;
      for (int i = 0; i < 4; i++) begin
         iMC_done = (i == 2);
         iMC_inst = mem(32'h300);
         step();
         if (oMC_en !== 1'b1 || oMC_addr !== 32'h300 || oIQ_en !== 1'b0) flag = 1'b1;
      end
      iMC_done = 1'b0;
      n_chk++;
      if (flag !== 1'b0) begin
         n_fail++;
         $display("FAIL rr_freeze: got change=%b want 0", flag);
      end
      rst = 1'b1;
      #1;
      n_chk++;
      if (oMC_en !== 1'b0 || oMC_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL rr_async: got en=%b addr=%h want 0/0", oMC_en, oMC_addr);
      end
      step();
      rst = 1'b0; rdy = 1'b1;
      step();
      n_chk++;
      if (oMC_en !== 1'b1 || oMC_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL rr_restart: got en=%b addr=%h want 1/0", oMC_en, oMC_addr);
      end
      exp_q.push_back({32'h0, 32'h13});
      serve(1, 1'b0, '0, stable);
      step();
      n_chk++;
      if (oMC_en !== 1'b1 || oMC_addr !== 32'h4) begin
         n_fail++;
         $display("FAIL rr_invalid: got en=%b addr=%h want 1/4", oMC_en, oMC_addr);
      end
      exp_q.push_back({32'h4, 32'h13});
      serve(1, 1'b0, '0, stable);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_chk++;
         if (obs_q.size() == 0) begin
            n_fail++;
            $display("FAIL rr_emit: got none want %h", e);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               n_fail++;
               $display("FAIL rr_emit: got %h want %h", o, e);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_cold_start();
      test_hit_stream();
      test_backpressure();
      test_redirect_miss();
      test_simul_done_jp();
      test_wrap();
      test_rdy_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
